// File: rtl/clock_pkg.sv
// +-------------------------------------------------------------------+
// | clock_pkg : shared types and constants for the hour keeper        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } adj_state_t;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [4:0] HOUR_MOD = 5'd24;

  // Display hours never exceed 23, so tens is at most 2.
  function automatic logic [5:0] to_bcd(input logic [4:0] v);
    if (v >= 5'd20)      return {2'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {2'd1, 4'(v - 5'd10)};
    else                 return {2'd0, v[3:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/adj_repeat.sv
// +-------------------------------------------------------------------+
// | adj_repeat : press/hold auto-repeat for the hour adjust buttons   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module adj_repeat
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY    = 50_000_000,
  parameter int REPEAT_PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic adj_up,
  input  logic adj_down,
  output logic step_up,
  output logic step_down
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PERIOD) ? REPEAT_DLY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);

  adj_state_t    state;
  logic [CW-1:0] cnt;
  logic          dir_up;
  logic          one_hot;
  logic          held;
  logic          step;

  assign one_hot = adj_up ^ adj_down;
  // A press only survives while the same single button stays down.
  assign held    = dir_up ? (adj_up & ~adj_down) : (adj_down & ~adj_up);

  // Steps are issued in the same cycle the press/expiry is seen.
  assign step      = (state == IDLE) ? one_hot : (held && cnt == '0);
  assign step_up   = step & ((state == IDLE) ? adj_up : dir_up);
  assign step_down = step & ((state == IDLE) ? adj_down : ~dir_up);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (one_hot) begin
            state  <= WAIT;
            cnt    <= DLY_LOAD;
            dir_up <= adj_up;
          end
        end
        WAIT, RPT: begin
          if (!held) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= RPT;
            cnt   <= PER_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/hour_keeper.sv
// +-------------------------------------------------------------------+
// | hour_keeper : 24 h hour counter with set, adjust and 12/24 h view |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module hour_keeper
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY    = 50_000_000,
  parameter int REPEAT_PERIOD = 12_500_000,
  parameter int RESET_HOUR    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1h,
  input  logic       mode_24h,
  input  logic       set_en,
  input  logic [4:0] set_val,
  input  logic       adj_up,
  input  logic       adj_down,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic [1:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       day_tick,
  output logic       set_err
);

  logic       step_up;
  logic       step_down;
  logic [4:0] hour_inc;
  logic [4:0] hour_dec;

  adj_repeat #(
    .REPEAT_DLY    (REPEAT_DLY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_adj (
    .clk       (clk),
    .rst       (rst),
    .adj_up    (adj_up),
    .adj_down  (adj_down),
    .step_up   (step_up),
    .step_down (step_down)
  );

  assign hour_inc = (hours == HOUR_MAX) ? 5'd0 : hours + 5'd1;
  assign hour_dec = (hours == 5'd0) ? (HOUR_MOD - 5'd1) : hours - 5'd1;

  // Only one source may move the hour per cycle: set, then adjust, then tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours    <= 5'(RESET_HOUR);
      day_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (set_en) begin
        if (set_val <= HOUR_MAX) hours   <= set_val;
        else                     set_err <= 1'b1;
      end else if (step_up) begin
        hours <= hour_inc;
      end else if (step_down) begin
        hours <= hour_dec;
      end else if (tick_1h) begin
        hours    <= hour_inc;
        day_tick <= (hours == HOUR_MAX);
      end
    end
  end

  always_comb begin
    disp_hours = hours;
    if (!mode_24h) begin
      if (hours == 5'd0)       disp_hours = 5'd12;
      else if (hours > 5'd12)  disp_hours = hours - 5'd12;
    end
  end

  assign pm                   = (hours >= 5'd12);
  assign {bcd_tens, bcd_ones} = to_bcd(disp_hours);

endmodule

`default_nettype wire

// File: tb/tb_hour_keeper.sv
// Directed and randomized checks of hour_keeper against a press-age reference model.
`default_nettype none

module tb_hour_keeper;

  localparam int DLY = 4;
  localparam int PER = 2;
  localparam int RH  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1h = 1'b0, mode_24h = 1'b1, set_en = 1'b0;
  logic [4:0] set_val = 5'd0;
  logic       adj_up = 1'b0, adj_down = 1'b0;
  logic [4:0] hours, disp_hours;
  logic       pm, day_tick, set_err;
  logic [1:0] bcd_tens;
  logic [3:0] bcd_ones;

  int errors = 0;
  int checks = 0;

  // Reference model: current hour, and how many cycles the current press has lasted.
  int mh   = RH;
  int age  = -1;
  int pdir = 0;
  bit exp_dt = 0;
  bit exp_se = 0;

  hour_keeper #(
    .REPEAT_DLY    (DLY),
    .REPEAT_PERIOD (PER),
    .RESET_HOUR    (RH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1h    (tick_1h),
    .mode_24h   (mode_24h),
    .set_en     (set_en),
    .set_val    (set_val),
    .adj_up     (adj_up),
    .adj_down   (adj_down),
    .hours      (hours),
    .disp_hours (disp_hours),
    .pm         (pm),
    .bcd_tens   (bcd_tens),
    .bcd_ones   (bcd_ones),
    .day_tick   (day_tick),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int e;
    e = mode_24h ? mh : ((mh % 12 == 0) ? 12 : mh % 12);
    check({tag, ".hours"}, 32'(hours), 32'(mh));
    check({tag, ".disp"},  32'(disp_hours), 32'(e));
    check({tag, ".pm"},    32'(pm), 32'(mh >= 12));
    check({tag, ".tens"},  32'(bcd_tens), 32'(e / 10));
    check({tag, ".ones"},  32'(bcd_ones), 32'(e % 10));
    check({tag, ".dtick"}, 32'(day_tick), 32'(exp_dt));
    check({tag, ".serr"},  32'(set_err), 32'(exp_se));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input bit tk, input bit md, input bit se,
                     input logic [4:0] sv, input bit up, input bit dn);
    int stp;
    int d;
    tick_1h = tk; mode_24h = md; set_en = se; set_val = sv; adj_up = up; adj_down = dn;
    stp = 0;
    if (up ^ dn) begin
      d = up ? 1 : -1;
      if (age >= 0 && d == pdir) age++;
      else if (age >= 0)         age = -1;
      else begin age = 0; pdir = d; end
    end else begin
      age = -1;
    end
    if (age == 0 || (age >= DLY && (age - DLY) % PER == 0)) stp = pdir;
    if (age < 0) stp = 0;
    exp_dt = 0;
    exp_se = 0;
    if (se) begin
      if (sv <= 23) mh = sv;
      else          exp_se = 1;
    end else if (stp != 0) begin
      mh = (mh + stp + 24) % 24;
    end else if (tk) begin
      if (mh == 23) begin mh = 0; exp_dt = 1; end
      else mh++;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle; inputs keep their current levels.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    mh = RH; age = -1; exp_dt = 0; exp_se = 0;
    check({tag, ".rst_hours"}, 32'(hours), 32'(RH));
    check({tag, ".rst_dtick"}, 32'(day_tick), 32'd0);
    check({tag, ".rst_serr"},  32'(set_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int pat;
    #1;
    do_reset("init");
    cyc("idle", 0, 1, 0, 0, 0, 0);

    // Natural rollover, shown in 12 h format.
    cyc("set23", 0, 1, 1, 5'd23, 0, 0);
    cyc("roll", 1, 0, 0, 0, 0, 0);
    check("roll.dt_const", 32'(day_tick), 32'd1);
    check("roll.disp12", 32'(disp_hours), 32'd12);
    check("roll.bcd", {26'd0, bcd_tens, bcd_ones}, 32'h12);
    cyc("roll_after", 0, 0, 0, 0, 0, 0);

    // Set beats tick; out-of-range set is rejected.
    cyc("set17tick", 1, 1, 1, 5'd17, 0, 0);
    check("set17.const", 32'(hours), 32'd17);
    cyc("set24", 1, 1, 1, 5'd24, 0, 0);
    check("set24.err", 32'(set_err), 32'd1);
    cyc("set24_after", 0, 1, 0, 0, 0, 0);

    // Held down from 0: steps at 0,4,6,8.
    cyc("set0", 0, 1, 1, 5'd0, 0, 0);
    for (int i = 0; i < 10; i++) cyc("hold_dn", 0, 1, 0, 0, 0, 1);
    check("hold_dn.final", 32'(hours), 32'd20);
    cyc("rel", 1, 1, 0, 0, 0, 0);

    // Both buttons: nothing happens, then a single press steps at once.
    for (int i = 0; i < 5; i++) cyc("both", 0, 1, 0, 0, 1, 1);
    cyc("after_both", 0, 1, 0, 0, 1, 0);
    cyc("rel2", 0, 1, 0, 0, 0, 0);

    // Direction flip without release.
    for (int i = 0; i < 6; i++) cyc("flip_up", 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc("flip_dn", 0, 1, 0, 0, 0, 1);

    // Reset in the middle of auto-repeat with the button still held.
    for (int i = 0; i < 7; i++) cyc("rpt_up", 0, 1, 0, 0, 1, 0);
    do_reset("midrpt");
    cyc("post_rst0", 0, 1, 0, 0, 1, 0);
    check("post_rst0.const", 32'(hours), 32'(RH + 1));
    for (int i = 0; i < 5; i++) cyc("post_rst", 0, 1, 0, 0, 1, 0);
    cyc("rel3", 0, 1, 0, 0, 0, 0);

    // 12 h sweep of every hour.
    for (int h = 0; h < 24; h++) cyc("sweep12", 0, 0, 1, 5'(h), 0, 0);

    // Randomized mix of all inputs.
    pat = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) pat = int'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) do_reset("rnd");
      cyc("rnd", $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 11) == 0, 5'($urandom_range(0, 31)),
          pat[0], pat[1]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hour_keeper.md
HOUR_KEEPER -- requirements
Module: hour_keeper

Interface
REQ-001 SHALL have parameter REPEAT_DLY, default 50_000_000, meaning cycles a held adjust button waits before auto-repeat starts (minimum 2).
REQ-002 SHALL have parameter REPEAT_PERIOD, default 12_500_000, meaning cycles between auto-repeat steps (minimum 2).
REQ-003 SHALL have parameter RESET_HOUR, default 0, meaning hour value loaded on reset (0..23).
REQ-004 SHALL have port clk  in  1, the single rising-edge clock.
REQ-005 SHALL have port rst  in  1, the asynchronous, active-low reset.
REQ-006 SHALL have port tick_1h  in  1, a one-cycle pulse that advances the hour.
REQ-007 SHALL have port mode_24h  in  1, display format select (1 = 24 h, 0 = 12 h), changeable any cycle.
REQ-008 SHALL have port set_en  in  1, a one-cycle load strobe.
REQ-009 SHALL have port set_val  in  5, the load value in 24 h binary.
REQ-010 SHALL have ports adj_up and adj_down  in  1 each, level inputs from buttons, already synchronised and debounced.
REQ-011 SHALL have port hours  out  5, the registered 24 h count (0..23).
REQ-012 SHALL have ports disp_hours  out  5 and pm  out  1, the formatted hour and the PM flag.
REQ-013 SHALL have ports bcd_tens  out  2 and bcd_ones  out  4, the BCD form of disp_hours.
REQ-014 SHALL have port day_tick  out  1, a one-cycle registered pulse on a natural 23->0 rollover.
REQ-015 SHALL have port set_err  out  1, a one-cycle registered pulse when set_val is out of range.

Function
REQ-016 SHALL apply update priority per cycle: set_en > adjust step > tick_1h; a lower-priority event in the same cycle is dropped.
REQ-017 set_en with set_val <= 23 SHALL load hours on the next edge; set_val > 23 SHALL leave hours unchanged and pulse set_err.
REQ-018 tick_1h SHALL increment hours, wrapping 23->0; only this wrap SHALL pulse day_tick, registered in the same edge as hours = 0.
REQ-019 Adjust steps SHALL increment (adj_up) or decrement (adj_down) hours modulo 24, with 0->23 on decrement, and SHALL never pulse day_tick.
REQ-020 The adjust FSM SHALL have states IDLE, WAIT and RPT.
REQ-021 IDLE: when exactly one adjust input is high, SHALL step once that cycle, load the delay counter with REPEAT_DLY-1, and go to WAIT.
REQ-022 WAIT: release or both-high SHALL go to IDLE with no step; counter reaching 0 SHALL step, load REPEAT_PERIOD-1, and go to RPT.
REQ-023 RPT: SHALL step each time the counter reaches 0 and reload it; release or both-high SHALL go to IDLE.
REQ-024 Both adjust inputs high in IDLE SHALL cause no step and no state change.
REQ-025 A direction change without passing through IDLE (up->down) SHALL count as a release.
REQ-026 disp_hours/pm SHALL be combinational from hours, with 0-cycle latency.
REQ-027 In 24 h mode, disp_hours SHALL equal hours.
REQ-028 In 12 h mode, the mapping SHALL be: 0->12; 1..11 unchanged; 12->12; 13..23->h-12.
REQ-029 pm SHALL be (hours >= 12) in both modes.
REQ-030 bcd_tens/bcd_ones SHALL be combinational from disp_hours (range 0..23, so tens <= 2).

Reset
REQ-031 Asserting rst low SHALL immediately set hours = RESET_HOUR, FSM = IDLE, delay counter = 0, and day_tick = set_err = 0, regardless of clk.
REQ-032 Reset asserted mid-repeat SHALL abandon the sequence; after release, a still-held button SHALL be treated as a new press from IDLE.

Structure
REQ-033 Package clock_pkg SHALL hold the FSM state enum, HOUR_MAX = 23 and HOUR_MOD = 24.
REQ-034 The adjust FSM and delay counter SHALL be sub-module adj_repeat, which outputs one-cycle step_up/step_down pulses.
REQ-035 The counter width in adj_repeat SHALL be $clog2 of max(REPEAT_DLY, REPEAT_PERIOD).

Verification (REPEAT_DLY = 4, REPEAT_PERIOD = 2)
REQ-036 hours = 23, tick_1h pulse -> next edge hours = 0, day_tick = 1 for exactly 1 cycle; mode_24h = 0 gives disp_hours = 12, pm = 0, bcd = 1/2.
REQ-037 set_en with set_val = 17 and tick_1h in the same cycle -> hours = 17, no day_tick; set_val = 24 -> hours unchanged, set_err = 1 for 1 cycle.
REQ-038 hours = 0, adj_down held for 10 cycles -> steps at cycles 0, 4, 6, 8, giving hours 23, 22, 21, 20; day_tick stays 0.
REQ-039 adj_up and adj_down both high for 5 cycles from IDLE -> hours unchanged, FSM stays IDLE.
REQ-040 rst low during RPT with adj_up still held -> hours = RESET_HOUR at once; after rst high, exactly one step on the first edge, then the next step 4 cycles later.
REQ-041 mode_24h = 0 sweep of hours 0..23 -> disp_hours 12, 1..11, 12, 1..11 with pm = 0 for hours 0..11 and pm = 1 for hours 12..23, and BCD matching each.
